// File: rtl/sw_reg_block.sv
// Register-bus leaf: R/W control registers plus saturating event counters; SW_REG_CLEAR_ON_READ_EN makes counter reads destructive.
// Latency: reg_ack and reg_rd_data one cycle after the reg_req rise; one ack per request, no backpressure (req must drop before the next access).
module sw_reg_block #(
    parameter int          REG_ADDR_WIDTH = 5,
    parameter int          NUM_RW_REGS    = 4,
    parameter int          NUM_CNTRS      = 4,
    parameter int          CNTR_WIDTH     = 32,
    parameter logic [31:0] RW_RESET_VAL   = 32'h0,
    parameter logic [31:0] UNUSED_RD_VAL  = 32'hDEAD_BEEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        reg_req,
    output logic                        reg_ack,
    input  logic                        reg_rd_wr_L,
    input  logic [REG_ADDR_WIDTH-1:0]   reg_addr,
    output logic [31:0]                 reg_rd_data,
    input  logic [31:0]                 reg_wr_data,
    output logic [NUM_RW_REGS*32-1:0]   rw_regs_out,
    input  logic [NUM_CNTRS-1:0]        cntr_inc
);

    localparam logic [CNTR_WIDTH-1:0] CNTR_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                      r_state;
    logic                        r_req_d1;
    logic [NUM_RW_REGS*32-1:0]   r_rw_regs;
    logic [31:0]                 w_addr;
    logic                        w_fire;
    logic                        w_cntr_clr_kind;
    logic [31:0]                 w_rd_val;
    logic [31:0]                 w_cntr_val [NUM_CNTRS];

    assign w_addr = 32'(reg_addr);
    assign w_fire = (r_state == S_IDLE) && reg_req && !r_req_d1;

`ifdef SW_REG_CLEAR_ON_READ_EN
    assign w_cntr_clr_kind = 1'b1;
`else
    assign w_cntr_clr_kind = !reg_rd_wr_L;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_req_d1    <= 1'b0;
            reg_ack     <= 1'b0;
            reg_rd_data <= 32'h0;
        end else begin
            r_req_d1 <= reg_req;
            reg_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        r_state     <= S_ACK;
                        reg_ack     <= 1'b1;
                        reg_rd_data <= reg_rd_wr_L ? w_rd_val : 32'h0;
                    end
                end
                S_ACK: begin
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (!reg_req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rw_regs <= {NUM_RW_REGS{RW_RESET_VAL}};
        end else begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                if (w_fire && !reg_rd_wr_L && (w_addr == 32'(i))) begin
                    r_rw_regs[32*i +: 32] <= reg_wr_data;
                end
            end
        end
    end

    assign rw_regs_out = r_rw_regs;

    genvar g;
    generate
        for (g = 0; g < NUM_CNTRS; g++) begin : g_cntr
            logic [CNTR_WIDTH-1:0] r_cnt;
            logic                  w_clr;

            assign w_clr = w_fire && w_cntr_clr_kind && (w_addr == 32'(NUM_RW_REGS + g));

            // A clear coinciding with an increment leaves the counter at 1, not 0.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (w_clr) begin
                    r_cnt <= CNTR_WIDTH'(cntr_inc[g]);
                end else if (cntr_inc[g] && (r_cnt != CNTR_MAX)) begin
                    r_cnt <= r_cnt + CNTR_WIDTH'(1);
                end
            end

            assign w_cntr_val[g] = 32'(r_cnt);
        end
    endgenerate

    always_comb begin
        w_rd_val = UNUSED_RD_VAL;
        for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (w_addr == 32'(i)) begin
                w_rd_val = r_rw_regs[32*i +: 32];
            end
        end
        for (int j = 0; j < NUM_CNTRS; j++) begin
            if (w_addr == 32'(NUM_RW_REGS + j)) begin
                w_rd_val = w_cntr_val[j];
            end
        end
    end

endmodule

// File: tb/tb_sw_reg_block.sv
// Randomized bench for sw_reg_block (4-bit counters) against an array-based reference model.
module tb_sw_reg_block;

    localparam int CW  = 4;
    localparam int NRW = 4;
    localparam int NC  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              reg_req;
    logic              reg_ack;
    logic              reg_rd_wr_L;
    logic [4:0]        reg_addr;
    logic [31:0]       reg_rd_data;
    logic [31:0]       reg_wr_data;
    logic [NRW*32-1:0] rw_regs_out;
    logic [NC-1:0]     cntr_inc;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_rw [NRW];
    int          m_cnt [NC];
    bit          clr_on_rd;
    bit          rand_inc;

    always #5 clk = ~clk;

    sw_reg_block #(
        .REG_ADDR_WIDTH (5),
        .NUM_RW_REGS    (NRW),
        .NUM_CNTRS      (NC),
        .CNTR_WIDTH     (CW),
        .RW_RESET_VAL   (32'h0),
        .UNUSED_RD_VAL  (32'hDEAD_BEEF)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .reg_req     (reg_req),
        .reg_ack     (reg_ack),
        .reg_rd_wr_L (reg_rd_wr_L),
        .reg_addr    (reg_addr),
        .reg_rd_data (reg_rd_data),
        .reg_wr_data (reg_wr_data),
        .rw_regs_out (rw_regs_out),
        .cntr_inc    (cntr_inc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NRW; i++) m_rw[i] = 32'h0;
        for (int j = 0; j < NC; j++) m_cnt[j] = 0;
    endtask

    // One clock: the model applies this edge's effects using the inputs seen at the edge.
    task automatic tick(input bit fire, output logic [31:0] exp_rd);
        int a;
        bit clr;
        @(posedge clk);
        a = int'(reg_addr);
        exp_rd = 32'h0;
        if (fire && reg_rd_wr_L) begin
            if (a < NRW)           exp_rd = m_rw[a];
            else if (a < NRW + NC) exp_rd = 32'(m_cnt[a - NRW]);
            else                   exp_rd = 32'hDEAD_BEEF;
        end
        for (int j = 0; j < NC; j++) begin
            clr = fire && (a == NRW + j) && (!reg_rd_wr_L || clr_on_rd);
            if (clr)                                  m_cnt[j] = cntr_inc[j] ? 1 : 0;
            else if (cntr_inc[j] && m_cnt[j] < (1 << CW) - 1) m_cnt[j] = m_cnt[j] + 1;
        end
        if (fire && !reg_rd_wr_L && a < NRW) m_rw[a] = reg_wr_data;
        @(negedge clk);
        if (rand_inc) cntr_inc = NC'($urandom);
    endtask

    task automatic check_rw(input string tag);
        for (int i = 0; i < NRW; i++) chk(tag, rw_regs_out[32*i +: 32], m_rw[i]);
    endtask

    // Full handshake: raise req, check the ack cycle, drop req, wait back to idle.
    task automatic access(input bit rd, input int addr, input logic [31:0] wd, output logic [31:0] rdata);
        logic [31:0] exp;
        logic [31:0] dummy;
        reg_rd_wr_L = rd;
        reg_addr    = 5'(addr);
        reg_wr_data = wd;
        reg_req     = 1'b1;
        tick(1'b1, exp);
        if (!rand_inc) cntr_inc = '0;
        chk("ack_on", 32'(reg_ack), 32'h1);
        chk("rd_data", reg_rd_data, exp);
        check_rw("rw_out");
        rdata   = reg_rd_data;
        reg_req = 1'b0;
        tick(1'b0, dummy);
        chk("ack_off", 32'(reg_ack), 32'h0);
        tick(1'b0, dummy);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] d;
        logic [31:0] wv;
        int          n_ack;

`ifdef SW_REG_CLEAR_ON_READ_EN
        clr_on_rd = 1'b1;
`else
        clr_on_rd = 1'b0;
`endif
        rand_inc    = 1'b0;
        reset_n     = 1'b0;
        reg_req     = 1'b0;
        reg_rd_wr_L = 1'b1;
        reg_addr    = '0;
        reg_wr_data = '0;
        cntr_inc    = '0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(reg_ack), 32'h0);
        chk("rst_rd", reg_rd_data, 32'h0);
        check_rw("rst_rw");
        reset_n = 1'b1;
        tick(1'b0, d);

        for (int a = 0; a < NRW; a++) begin
            access(1'b1, a, 32'h0, rd);
            chk("rst_rw_rd", rd, 32'h0);
        end
        access(1'b1, 8, 32'h0, rd);
        chk("unmapped8", rd, 32'hDEAD_BEEF);
        access(1'b1, 31, 32'h0, rd);
        chk("unmapped31", rd, 32'hDEAD_BEEF);

        access(1'b0, 2, 32'h1234_5678, rd);
        chk("wr_rd0", rd, 32'h0);
        access(1'b1, 2, 32'h0, rd);
        chk("rw2_rd", rd, 32'h1234_5678);
        chk("rw2_out", rw_regs_out[95:64], 32'h1234_5678);
        access(1'b0, 20, 32'hFFFF_FFFF, rd);
        access(1'b1, 2, 32'h0, rd);
        chk("wr20_ignored", rd, 32'h1234_5678);

        // Long request: exactly one ack, then a re-raise gets a second one.
        reg_rd_wr_L = 1'b1;
        reg_addr    = 5'd2;
        reg_req     = 1'b1;
        n_ack       = 0;
        tick(1'b1, d);
        if (reg_ack) n_ack++;
        for (int k = 0; k < 9; k++) begin
            tick(1'b0, d);
            if (reg_ack) n_ack++;
        end
        chk("hold_one_ack", 32'(n_ack), 32'h1);
        reg_req = 1'b0;
        tick(1'b0, d);
        tick(1'b0, d);
        access(1'b1, 2, 32'h0, rd);
        chk("reraise_rd", rd, 32'h1234_5678);

        cntr_inc = 4'b0001;
        repeat (20) tick(1'b0, d);
        cntr_inc = '0;
        access(1'b1, 4, 32'h0, rd);
        chk("sat", rd, 32'h0000_000F);

        cntr_inc = 4'b0010;
        repeat (5) tick(1'b0, d);
        cntr_inc = '0;
        access(1'b1, 5, 32'h0, rd);
        chk("c1_rd1", rd, 32'h5);
        access(1'b1, 5, 32'h0, rd);
        chk("c1_rd2", rd, clr_on_rd ? 32'h0 : 32'h5);
        cntr_inc = 4'b0010;
        access(1'b0, 5, 32'hABCD_0123, rd);
        access(1'b1, 5, 32'h0, rd);
        chk("clr_inc", rd, 32'h1);

        // Reset arriving while the FSM holds with reg_req still high.
        wv = $urandom;
        access(1'b0, 1, wv, rd);
        reg_rd_wr_L = 1'b1;
        reg_addr    = 5'd1;
        reg_req     = 1'b1;
        tick(1'b1, d);
        chk("pre_rst_ack", 32'(reg_ack), 32'h1);
        chk("pre_rst_rd", reg_rd_data, wv);
        tick(1'b0, d);
        reset_n = 1'b0;
        #1;
        m_reset();
        chk("mid_rst_ack", 32'(reg_ack), 32'h0);
        chk("mid_rst_rd", reg_rd_data, 32'h0);
        check_rw("mid_rst_rw");
        @(negedge clk);
        reset_n = 1'b1;
        n_ack   = 0;
        tick(1'b1, d);
        if (reg_ack) n_ack++;
        chk("post_rst_rd", reg_rd_data, d);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, d);
            if (reg_ack) n_ack++;
        end
        chk("post_rst_one_ack", 32'(n_ack), 32'h1);
        reg_req = 1'b0;
        tick(1'b0, d);
        tick(1'b0, d);
        for (int j = 0; j < NC; j++) begin
            access(1'b1, NRW + j, 32'h0, rd);
        end

        rand_inc = 1'b1;
        for (int n = 0; n < 120; n++) begin
            access(bit'($urandom_range(0, 1)), int'($urandom_range(0, 11) == 11 ? $urandom_range(8, 31) : $urandom_range(0, 7)),
                   $urandom, rd);
        end
        rand_inc = 1'b0;
        cntr_inc = '0;
        tick(1'b0, d);
        for (int a = 0; a < NRW + NC; a++) begin
            access(1'b1, a, 32'h0, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
